// File: rtl/uart_word_tx_pkg.sv
// Shared UART definitions for the word transmitter and the loader's receiver.
package uart_word_tx_pkg;

   localparam int unsigned UART_DATA_BITS = 8;
   localparam int unsigned WORD_W         = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// Byte-level 8N1 serialiser; a new byte may be taken at the end of a stop bit
// so consecutive frames follow with no idle gap.
module uart_byte_tx
   import uart_word_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] byte_data,
   input  logic       byte_valid,
   output logic       byte_ready_c,
   output logic       idle_c,
   output logic       frame_done_c,
   output logic       tx,
   output logic       busy
);

   localparam int unsigned CLK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = $clog2(UART_DATA_BITS);

   uart_state_e               state, state_d;
   logic [CLK_W-1:0]          bit_clk, bit_clk_d;
   logic [BIT_W-1:0]          bit_idx, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shreg, shreg_d;
   logic                      tx_d;
   logic                      bit_end;

   assign bit_end      = (bit_clk == CLK_W'(CLKS_PER_BIT - 1));
   assign idle_c       = (state == ST_IDLE);
   assign frame_done_c = (state == ST_STOP) && bit_end;
   assign byte_ready_c = !rst && (idle_c || frame_done_c);

   // Next-state and next-value logic; tx is registered from tx_d.
   always_comb begin
      state_d   = state;
      bit_clk_d = bit_clk + CLK_W'(1);
      bit_idx_d = bit_idx;
      shreg_d   = shreg;
      tx_d      = tx;
      case (state)
         ST_IDLE: begin
            bit_clk_d = '0;
            if (byte_valid) begin
               state_d   = ST_START;
               shreg_d   = byte_data;
               bit_idx_d = '0;
               tx_d      = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_clk_d = '0;
               tx_d      = shreg_d[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               bit_clk_d = '0;
               if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx + BIT_W'(1);
                  shreg_d   = shreg >> 1;
                  tx_d      = shreg_d[0];
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               bit_clk_d = '0;
               bit_idx_d = '0;
               if (byte_valid) begin
                  state_d = ST_START;
                  shreg_d = byte_data;
                  tx_d    = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         bit_clk <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state   <= state_d;
         bit_clk <= bit_clk_d;
         bit_idx <= bit_idx_d;
         shreg   <= shreg_d;
         tx      <= tx_d;
         busy    <= (state_d != ST_IDLE);
      end
   end

endmodule

// File: rtl/uart_word_tx.sv
// Word sequencer: latches a word on handshake and feeds its bytes, LSB first,
// to the byte serialiser; counts completed words.
module uart_word_tx
   import uart_word_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT   = 16,
   parameter int unsigned BYTES_PER_WORD = 4,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      word_data,
   input  logic             word_valid,
   output logic             word_ready,
   output logic             tx,
   output logic             busy,
   output logic [CNT_W-1:0] words_sent
);

   localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

   logic [WORD_W-1:0] word_sh;
   logic [IDX_W-1:0]  byte_idx;
   logic [7:0]        byte_data;
   logic              byte_valid;
   logic              byte_ready_c;
   logic              idle_c;
   logic              frame_done_c;
   logic              last_byte;
   logic              byte_take;

   assign last_byte  = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));
   assign word_ready = idle_c && !rst;
   // In IDLE the first byte goes straight from word_data so tx falls right after accept.
   assign byte_valid = idle_c ? word_valid : !last_byte;
   assign byte_data  = idle_c ? word_data[7:0] : word_sh[7:0];
   assign byte_take  = byte_valid && byte_ready_c;

   uart_byte_tx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte_tx (
      .clk         (clk),
      .rst         (rst),
      .byte_data   (byte_data),
      .byte_valid  (byte_valid),
      .byte_ready_c(byte_ready_c),
      .idle_c      (idle_c),
      .frame_done_c(frame_done_c),
      .tx          (tx),
      .busy        (busy)
   );

   // word_sh always holds the next byte to send in its low 8 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_sh    <= '0;
         byte_idx   <= '0;
         words_sent <= '0;
      end else if (byte_take) begin
         if (idle_c) begin
            word_sh  <= word_data >> 8;
            byte_idx <= '0;
         end else begin
            word_sh  <= word_sh >> 8;
            byte_idx <= byte_idx + IDX_W'(1);
         end
      end else if (frame_done_c) begin
         byte_idx   <= '0;
         words_sent <= words_sent + CNT_W'(1);
      end
   end

endmodule
